dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_align.sv | 38 +++
 rtl/dcache_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Optional feature macro used by the cache: DCACHE_STATS_EN (hit/miss counters).
package dcache_pkg;

    // Width of one memory beat in bytes.
    localparam int BEAT_BYTES = 8;

    // Load/store size encoding taken directly from the funct3 field.
    typedef enum logic [2:0] {
        SIZE_B  = 3'd0,
        SIZE_H  = 3'd1,
        SIZE_W  = 3'd2,
        SIZE_D  = 3'd3,
        SIZE_BU = 3'd4,
        SIZE_HU = 3'd5,
        SIZE_WU = 3'd6,
        SIZE_DX = 3'd7
    } size_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WMEM = 2'd2,
        RESP = 2'd3
    } state_e;

    // Byte-enable pattern for an access of the given size, starting at lane 0.
    function automatic logic [7:0] sizeMask(input size_e size);
        case (size)
            SIZE_B, SIZE_BU: sizeMask = 8'h01;
            SIZE_H, SIZE_HU: sizeMask = 8'h03;
            SIZE_W, SIZE_WU: sizeMask = 8'h0F;
            default:         sizeMask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/dcache_align.sv
// Byte-lane alignment for the data cache: load extraction with sign/zero
// extension and store lane shifting with byte strobes. Purely combinational.
// Bytes that would fall beyond the 64-bit beat are silently dropped.
module dcache_align
    import dcache_pkg::*;
(
    input  size_e       size_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] loadBeat_i,
    input  logic [63:0] storeData_i,
    output logic [63:0] loadData_o,
    output logic [63:0] storeLane_o,
    output logic [7:0]  storeStrb_o
);

    logic [63:0] shifted;

    // Move the addressed byte down to lane 0, then extend according to size.
    always_comb begin
        shifted = loadBeat_i >> {offset_i, 3'b000};
        case (size_i)
            SIZE_B:  loadData_o = {{56{shifted[7]}}, shifted[7:0]};
            SIZE_H:  loadData_o = {{48{shifted[15]}}, shifted[15:0]};
            SIZE_W:  loadData_o = {{32{shifted[31]}}, shifted[31:0]};
            SIZE_BU: loadData_o = {56'd0, shifted[7:0]};
            SIZE_HU: loadData_o = {48'd0, shifted[15:0]};
            SIZE_WU: loadData_o = {32'd0, shifted[31:0]};
            default: loadData_o = shifted;
        endcase
    end

    // Place right-aligned store data in its byte lanes and build the strobe.
    always_comb begin
        storeLane_o = storeData_i << {offset_i, 3'b000};
        storeStrb_o = sizeMask(size_i) << offset_i;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses fill a whole line beat by beat; writes always go to memory and
// update the line in place when it is already cached.
// Define DCACHE_STATS_EN to add the stat_hits/stat_misses read counters.
// LINE_BEATS must be at least 2.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dc_read_req,
    input  logic        dc_write_req,
    input  logic [63:0] dc_addr,
    input  logic [63:0] dc_wdata,
    input  logic [2:0]  dc_size,
    output logic        dc_read_done,
    output logic        dc_write_done,
    output logic [63:0] dc_read_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [63:0] stat_hits,
    output logic [63:0] stat_misses
`endif
);

    localparam int BEAT_OFF  = $clog2(BEAT_BYTES);
    localparam int OFF_BITS  = $clog2(BEAT_BYTES * LINE_BEATS);
    localparam int BEAT_BITS = $clog2(LINE_BEATS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = 64 - OFF_BITS - IDX_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

    state_e               state_q;
    logic [BEAT_BITS-1:0] beatCnt_q;
    logic [SETS-1:0]      valid_q;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [63:0]          data_q [SETS][LINE_BEATS];

    logic                 readDone_q;
    logic                 writeDone_q;
    logic [63:0]          readData_q;
    logic                 memReq_q;
    logic                 memWe_q;
    logic [63:0]          memAddr_q;
    logic [63:0]          memWdata_q;
    logic [7:0]           memWstrb_q;

    logic [IDX_BITS-1:0]  reqIdx;
    logic [BEAT_BITS-1:0] reqBeat;
    logic [TAG_BITS-1:0]  reqTag;
    logic [63:0]          lineBase;
    logic                 hit;
    logic                 fillAck;
    logic                 fillLast;
    logic [63:0]          loadBeat;
    logic [63:0]          loadData;
    logic [63:0]          storeLane;
    logic [7:0]           storeStrb;
    logic [63:0]          mergedBeat;

    assign reqIdx   = dc_addr[OFF_BITS +: IDX_BITS];
    assign reqBeat  = dc_addr[BEAT_OFF +: BEAT_BITS];
    assign reqTag   = dc_addr[63 -: TAG_BITS];
    assign lineBase = {dc_addr[63:OFF_BITS], OFF_BITS'(0)};
    assign hit      = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
    assign fillAck  = (state_q == FILL) && mem_ack;
    assign fillLast = fillAck && (beatCnt_q == LAST_BEAT);

    // The requested beat may be arriving right now on the final fill beat.
    assign loadBeat = (fillAck && (beatCnt_q == reqBeat)) ? mem_rdata
                                                          : data_q[reqIdx][reqBeat];

    dcache_align u_align (
        .size_i      (size_e'(dc_size)),
        .offset_i    (dc_addr[2:0]),
        .loadBeat_i  (loadBeat),
        .storeData_i (dc_wdata),
        .loadData_o  (loadData),
        .storeLane_o (storeLane),
        .storeStrb_o (storeStrb)
    );

    // Byte-merge the store into the currently cached beat for write hits.
    always_comb begin
        mergedBeat = data_q[reqIdx][reqBeat];
        for (int b = 0; b < BEAT_BYTES; b++) begin
            if (storeStrb[b]) begin
                mergedBeat[8*b +: 8] = storeLane[8*b +: 8];
            end
        end
    end

    // Line storage: fill beats as they arrive, merge write hits while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fillAck) begin
                data_q[reqIdx][beatCnt_q] <= mem_rdata;
                if (fillLast) begin
                    tag_q[reqIdx] <= reqTag;
                end
            end else if ((state_q == IDLE) && dc_write_req && hit) begin
                data_q[reqIdx][reqBeat] <= mergedBeat;
            end
        end
    end

    // Main controller FSM with registered request and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beatCnt_q   <= '0;
            valid_q     <= '0;
            readDone_q  <= 1'b0;
            writeDone_q <= 1'b0;
            readData_q  <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memWstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dc_write_req) begin
                        state_q    <= WMEM;
                        memReq_q   <= 1'b1;
                        memWe_q    <= 1'b1;
                        memAddr_q  <= {dc_addr[63:3], 3'b000};
                        memWdata_q <= storeLane;
                        memWstrb_q <= storeStrb;
                    end else if (dc_read_req) begin
                        if (hit) begin
                            state_q    <= RESP;
                            readDone_q <= 1'b1;
                            readData_q <= loadData;
                        end else begin
                            state_q   <= FILL;
                            beatCnt_q <= '0;
                            memReq_q  <= 1'b1;
                            memWe_q   <= 1'b0;
                            memAddr_q <= lineBase;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (beatCnt_q == LAST_BEAT) begin
                            state_q         <= RESP;
                            memReq_q        <= 1'b0;
                            valid_q[reqIdx] <= 1'b1;
                            readDone_q      <= 1'b1;
                            readData_q      <= loadData;
                        end else begin
                            beatCnt_q <= beatCnt_q + 1'b1;
                            memAddr_q <= memAddr_q + 64'd8;
                        end
                    end
                end
                WMEM: begin
                    if (mem_ack) begin
                        state_q     <= RESP;
                        memReq_q    <= 1'b0;
                        memWe_q     <= 1'b0;
                        writeDone_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    readDone_q  <= 1'b0;
                    writeDone_q <= 1'b0;
                end
            endcase
        end
    end

    assign dc_read_done  = readDone_q;
    assign dc_write_done = writeDone_q;
    assign dc_read_data  = readData_q;
    assign mem_req       = memReq_q;
    assign mem_we        = memWe_q;
    assign mem_addr      = memAddr_q;
    assign mem_wdata     = memWdata_q;
    assign mem_wstrb     = memWstrb_q;

`ifdef DCACHE_STATS_EN
    logic [63:0] hits_q;
    logic [63:0] misses_q;

    // Count read lookups as they leave IDLE, split by hit or miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if ((state_q == IDLE) && dc_read_req && !dc_write_req) begin
            if (hit) begin
                hits_q <= hits_q + 64'd1;
            end else begin
                misses_q <= misses_q + 64'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
